vga_sync_gen: RTL and testbench

- Timing source for the VGA pixel pipeline. Derives a pixel-rate enable from the system clock.
- Runs horizontal and vertical counters and produces the sync pulses.
- Broadcasts h_cnt, v_cnt, vsync, valid and frame markers to every renderer: ground, dino, obstacles, score.
- Renderers consume h_cnt/v_cnt as the current pixel position and use vsync edges for once-per-frame updates.

---
 rtl/vga_sync_gen.sv | 117 +++++++++++
 tb/tb_vga_sync_gen.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// VGA timing source: pixel-rate enable, horizontal/vertical counters, sync pulses and
// frame markers shared by every renderer in the pixel pipeline.
module vga_sync_gen #(
   parameter int unsigned DIV      = 4,    // system clocks per pixel, 1..16
   parameter int unsigned H_VIS    = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_VIS    = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33,
   parameter bit          SYNC_POL = 1'b0  // active level of hsync/vsync
) (
   input  logic        clk,
   input  logic        rst,
   output logic        pix_en,
   output logic [9:0]  h_cnt,
   output logic [9:0]  v_cnt,
   output logic        hsync,
   output logic        vsync,
   output logic        valid,
   output logic        line_start,
   output logic        frame_start,
   output logic [15:0] frame_cnt
);

   localparam int unsigned HTotal = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int unsigned VTotal = V_VIS + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] HLast     = 10'(HTotal - 1);
   localparam logic [9:0] VLast     = 10'(VTotal - 1);
   localparam logic [9:0] HVisEnd   = 10'(H_VIS);
   localparam logic [9:0] VVisEnd   = 10'(V_VIS);
   localparam logic [9:0] HSyncBeg  = 10'(H_VIS + H_FP);
   localparam logic [9:0] HSyncEnd  = 10'(H_VIS + H_FP + H_SYNC);
   localparam logic [9:0] VSyncBeg  = 10'(V_VIS + V_FP);
   localparam logic [9:0] VSyncEnd  = 10'(V_VIS + V_FP + V_SYNC);
   localparam logic [3:0] DivLast   = 4'(DIV - 1);

   logic [3:0]  div_q;
   logic        pix_en_q;
   logic [9:0]  h_q, h_d;
   logic [9:0]  v_q, v_d;
   logic        hsync_q, hsync_d;
   logic        vsync_q, vsync_d;
   logic        valid_q, valid_d;
   logic        line_start_q, line_start_d;
   logic        frame_start_q, frame_start_d;
   logic [15:0] frame_cnt_q, frame_cnt_d;

   // Clock divider; pix_en is registered so it lands one clk after div_q hits its last value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q    <= 4'd0;
         pix_en_q <= 1'b0;
      end else begin
         pix_en_q <= (div_q == DivLast);
         div_q    <= (div_q == DivLast) ? 4'd0 : div_q + 4'd1;
      end
   end

   // Next-count and decode; syncs/valid come from the next count so they line up with it.
   always_comb begin
      h_d = h_q;
      v_d = v_q;
      if (pix_en_q) begin
         if (h_q == HLast) begin
            h_d = 10'd0;
            v_d = (v_q == VLast) ? 10'd0 : v_q + 10'd1;
         end else begin
            h_d = h_q + 10'd1;
         end
      end
      hsync_d       = (h_d >= HSyncBeg && h_d < HSyncEnd) ? SYNC_POL : ~SYNC_POL;
      vsync_d       = (v_d >= VSyncBeg && v_d < VSyncEnd) ? SYNC_POL : ~SYNC_POL;
      valid_d       = (h_d < HVisEnd) && (v_d < VVisEnd);
      // Markers fire only on an actual advance, so reset itself never raises them.
      line_start_d  = pix_en_q && (h_d == 10'd0);
      frame_start_d = line_start_d && (v_d == 10'd0);
      frame_cnt_d   = frame_cnt_q + {15'd0, frame_start_d};
   end

   // Counter, sync and marker state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h_q           <= 10'd0;
         v_q           <= 10'd0;
         hsync_q       <= ~SYNC_POL;
         vsync_q       <= ~SYNC_POL;
         valid_q       <= 1'b1;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
         frame_cnt_q   <= 16'd0;
      end else begin
         h_q           <= h_d;
         v_q           <= v_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         valid_q       <= valid_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
         frame_cnt_q   <= frame_cnt_d;
      end
   end

   assign pix_en      = pix_en_q;
   assign h_cnt       = h_q;
   assign v_cnt       = v_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign valid       = valid_q;
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;
   assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a full-size instance (DIV=4, 640x480 timing) and a tiny DIV=1
// instance, both scored every clock against a closed-form model of pixel position.
module tb_vga_sync_gen;

   typedef struct packed {
      logic        pix_en;
      logic [9:0]  h;
      logic [9:0]  v;
      logic        hs;
      logic        vs;
      logic        valid;
      logic        ls;
      logic        fs;
      logic [15:0] fc;
   } exp_t;

   logic clk;
   logic rst_a, rst_b;

   logic        pe_a, hs_a, vs_a, va_a, ls_a, fs_a;
   logic [9:0]  h_a, v_a;
   logic [15:0] fc_a;
   logic        pe_b, hs_b, vs_b, va_b, ls_b, fs_b;
   logic [9:0]  h_b, v_b;
   logic [15:0] fc_b;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;
   int unsigned k_a = 0, k_b = 0;   // clock edges since reset release
   int unsigned off_b = 0;          // frame_cnt offset after the forced preload
   exp_t q_a[$];
   exp_t q_b[$];

   vga_sync_gen #(.DIV(4)) dut_a (
      .clk(clk), .rst(rst_a), .pix_en(pe_a), .h_cnt(h_a), .v_cnt(v_a), .hsync(hs_a),
      .vsync(vs_a), .valid(va_a), .line_start(ls_a), .frame_start(fs_a), .frame_cnt(fc_a)
   );

   vga_sync_gen #(
      .DIV(1), .H_VIS(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_VIS(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b0)
   ) dut_b (
      .clk(clk), .rst(rst_b), .pix_en(pe_b), .h_cnt(h_b), .v_cnt(v_b), .hsync(hs_b),
      .vsync(vs_b), .valid(va_b), .line_start(ls_b), .frame_start(fs_b), .frame_cnt(fc_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Expected outputs after k edges: pixel index p = floor((k-1)/div), positions derived from p.
   function automatic exp_t model(input int unsigned k, input int unsigned div,
                                  input int unsigned hv, input int unsigned hf,
                                  input int unsigned hsw, input int unsigned hb,
                                  input int unsigned vv, input int unsigned vf,
                                  input int unsigned vsw, input int unsigned vb,
                                  input bit pol, input int unsigned off);
      int unsigned ht = hv + hf + hsw + hb;
      int unsigned vt = vv + vf + vsw + vb;
      int unsigned p  = (k == 0) ? 0 : (k - 1) / div;
      int unsigned pp = (k <= 1) ? 0 : (k - 2) / div;
      int unsigned h  = p % ht;
      int unsigned v  = (p / ht) % vt;
      int unsigned fr = p / (ht * vt);
      exp_t e;
      e.pix_en = (k > 0) && (k % div == 0);
      e.h      = 10'(h);
      e.v      = 10'(v);
      e.hs     = (h >= hv + hf && h < hv + hf + hsw) ? pol : ~pol;
      e.vs     = (v >= vv + vf && v < vv + vf + vsw) ? pol : ~pol;
      e.valid  = (h < hv) && (v < vv);
      e.ls     = (p != pp) && (h == 0);
      e.fs     = e.ls && (v == 0);
      e.fc     = 16'((fr + off) & 32'hFFFF);
      return e;
   endfunction

   function automatic exp_t exp_a(input int unsigned k);
      return model(k, 4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 0);
   endfunction

   function automatic exp_t exp_b(input int unsigned k, input int unsigned off);
      return model(k, 1, 4, 1, 2, 1, 3, 1, 1, 1, 1'b0, off);
   endfunction

   function automatic exp_t got_a();
      return '{pe_a, h_a, v_a, hs_a, vs_a, va_a, ls_a, fs_a, fc_a};
   endfunction

   function automatic exp_t got_b();
      return '{pe_b, h_b, v_b, hs_b, vs_b, va_b, ls_b, fs_b, fc_b};
   endfunction

   task automatic cmp(input string pre, input exp_t g, input exp_t e);
      check({pre, ".pix_en"},      32'(g.pix_en), 32'(e.pix_en));
      check({pre, ".h_cnt"},       32'(g.h),      32'(e.h));
      check({pre, ".v_cnt"},       32'(g.v),      32'(e.v));
      check({pre, ".hsync"},       32'(g.hs),     32'(e.hs));
      check({pre, ".vsync"},       32'(g.vs),     32'(e.vs));
      check({pre, ".valid"},       32'(g.valid),  32'(e.valid));
      check({pre, ".line_start"},  32'(g.ls),     32'(e.ls));
      check({pre, ".frame_start"}, 32'(g.fs),     32'(e.fs));
      check({pre, ".frame_cnt"},   32'(g.fc),     32'(e.fc));
   endtask

   // One clock: push expectations at the edge, pop and score them on the falling edge.
   task automatic step();
      exp_t ea, eb;
      @(posedge clk);
      if (!rst_a) k_a++;
      if (!rst_b) k_b++;
      q_a.push_back(exp_a(k_a));
      q_b.push_back(exp_b(k_b, off_b));
      @(negedge clk);
      ea = q_a.pop_front();
      eb = q_b.pop_front();
      cmp("A", got_a(), ea);
      cmp("B", got_b(), eb);
   endtask

   initial begin
      exp_t        cur_a;
      bit          done_a = 1'b0;
      bit          vs_prev = 1'b1;
      int unsigned edges = 0;
      int unsigned frames = 0;
      int unsigned fr_now;

      rst_a = 1'b1;
      rst_b = 1'b1;
      #1;
      cmp("A.reset", got_a(), exp_a(0));
      cmp("B.reset", got_b(), exp_b(0, 0));
      repeat (3) step();
      #1;
      rst_a = 1'b0;
      rst_b = 1'b0;

      for (int cyc = 0; cyc < 7000; cyc++) begin
         step();
         if (cyc >= 100 && cyc < 2900) begin
            if (vs_b && !vs_prev) edges++;
            if (fs_b) frames++;
         end
         vs_prev = vs_b;

         // Preload frame_cnt just below the wrap point.
         if (cyc == 3000) begin
            #1;
            force dut_b.frame_cnt_q = 16'hFFFE;
            fr_now = ((k_b - 1) / 48);
            off_b  = (32'hFFFE - fr_now) & 32'hFFFF;
            #1;
            release dut_b.frame_cnt_q;
         end

         // Asynchronous reset of the full-size instance mid-line at (300, 1).
         cur_a = exp_a(k_a);
         if (!done_a && cur_a.h == 10'd300 && cur_a.v == 10'd1) begin
            done_a = 1'b1;
            check("A.pre_rst_h_cnt", 32'(h_a), 32'd300);
            #1;
            rst_a = 1'b1;
            #1;
            k_a = 0;
            cmp("A.async_rst", got_a(), exp_a(0));
            step();
            step();
            #1;
            rst_a = 1'b0;
         end

         // Asynchronous reset of the small instance mid-frame.
         if (cyc == 6000) begin
            #1;
            rst_b = 1'b1;
            #1;
            k_b   = 0;
            off_b = 0;
            cmp("B.async_rst", got_b(), exp_b(0, 0));
            step();
            step();
            #1;
            rst_b = 1'b0;
         end
      end

      check("A.mid_line_reset_seen", 32'(done_a), 32'd1);
      check("B.vsync_edges_per_frame", edges, frames);
      check("B.frames_in_window", frames, 32'd58);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
